lp_core_arbiter: RTL and testbench

// - Tracks which LP and timestamp each core is processing, and serialises cores that hit the same LP.
// - On retire, releases the stalled core for that LP with the smallest timestamp.
// - Sweeps the core table at a configurable rate to publish a GVT lower bound.
// - Sits between the event queue dispatcher and the core array. Successor of the fixed 4-core monitor:
//   any NUM_CORE, configurable scan width, explicit per-core FSM, error flags.

---
 rtl/lp_core_arbiter_if.sv | 34 +++
 rtl/lp_core_arbiter.sv | 155 +++++++++++++++
 tb/tb_lp_core_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lp_core_arbiter_if.sv
// Dispatcher <-> arbiter bus: event issue/retire requests in, per-core stall,
// release notification, occupancy, GVT bound and error pulse out.
interface lp_core_arbiter_if #(
  parameter int NUM_CORE = 8,
  parameter int NUM_LP   = 64,
  parameter int TIME_WID = 16
);
  localparam int NB_COREID = $clog2(NUM_CORE);
  localparam int NB_LPID   = $clog2(NUM_LP);

  logic                 issue_vld;
  logic [NB_COREID-1:0] issue_core;
  logic [NB_LPID-1:0]   issue_lp;
  logic [TIME_WID-1:0]  issue_time;
  logic                 retire_vld;
  logic [NB_COREID-1:0] retire_core;
  logic [NUM_CORE-1:0]  stall;
  logic                 release_vld;
  logic [NB_COREID-1:0] release_core;
  logic [NB_COREID:0]   active_cnt;
  logic [TIME_WID-1:0]  gvt;
  logic                 gvt_vld;
  logic                 err;

  modport master (
    output issue_vld, issue_core, issue_lp, issue_time, retire_vld, retire_core,
    input  stall, release_vld, release_core, active_cnt, gvt, gvt_vld, err
  );

  modport slave (
    input  issue_vld, issue_core, issue_lp, issue_time, retire_vld, retire_core,
    output stall, release_vld, release_core, active_cnt, gvt, gvt_vld, err
  );
endinterface

// File: rtl/lp_core_arbiter.sv
// Per-core LP/timestamp tracker: serialises cores on the same LP, releases the
// oldest waiter on retire, and sweeps the core table to publish a GVT bound.
module lp_core_arbiter #(
  parameter int NUM_CORE   = 8,
  parameter int NUM_LP     = 64,
  parameter int TIME_WID   = 16,
  parameter int SCAN_WIDTH = 2
) (
  input logic              clk,
  input logic              reset,
  lp_core_arbiter_if.slave bus
);
  localparam int NB_COREID = $clog2(NUM_CORE);
  localparam int NB_LPID   = $clog2(NUM_LP);
  localparam int NUM_GRP   = (NUM_CORE + SCAN_WIDTH - 1) / SCAN_WIDTH;
  localparam int NB_GRP    = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, STALL} core_st_e;

  core_st_e             st_q   [NUM_CORE];
  core_st_e             st_d   [NUM_CORE];
  logic [NB_LPID-1:0]   lp_q   [NUM_CORE];
  logic [NB_LPID-1:0]   lp_d   [NUM_CORE];
  logic [TIME_WID-1:0]  time_q [NUM_CORE];
  logic [TIME_WID-1:0]  time_d [NUM_CORE];

  logic [NUM_CORE-1:0]  stall_q, stall_d;
  logic                 release_vld_q, release_vld_d;
  logic [NB_COREID-1:0] release_core_q, release_core_d;
  logic [NB_COREID:0]   active_cnt_q, active_cnt_d;
  logic [TIME_WID-1:0]  gvt_q, gvt_d;
  logic                 gvt_vld_q, gvt_vld_d;
  logic                 err_q, err_d;
  logic [NB_GRP-1:0]    grp_q, grp_d;
  logic [TIME_WID-1:0]  acc_q, acc_d;
  logic [TIME_WID-1:0]  msg_q, msg_d;

  logic                 retire_ok, issue_ok, conflict, rel_found;
  logic [NB_COREID-1:0] rel_core;
  logic [TIME_WID-1:0]  rel_time, acc_n, msg_n;

  always_comb begin
    st_d   = st_q;
    lp_d   = lp_q;
    time_d = time_q;

    // Retire and release resolve first so the issue sees the post-retire table.
    retire_ok = bus.retire_vld && (int'(bus.retire_core) < NUM_CORE) &&
                (st_q[bus.retire_core] == RUN);
    rel_found = 1'b0;
    rel_core  = '0;
    rel_time  = '1;
    for (int c = 0; c < NUM_CORE; c++) begin
      if (retire_ok && st_q[c] == STALL && lp_q[c] == lp_q[bus.retire_core] &&
          (!rel_found || time_q[c] < rel_time)) begin
        rel_found = 1'b1;
        rel_core  = NB_COREID'(c);
        rel_time  = time_q[c];
      end
    end
    if (retire_ok) st_d[bus.retire_core] = IDLE;
    if (rel_found) st_d[rel_core] = RUN;

    issue_ok = bus.issue_vld && (int'(bus.issue_core) < NUM_CORE) &&
               (st_d[bus.issue_core] == IDLE);
    conflict = 1'b0;
    for (int c = 0; c < NUM_CORE; c++) begin
      if (c != int'(bus.issue_core) && st_d[c] != IDLE && lp_q[c] == bus.issue_lp)
        conflict = 1'b1;
    end
    if (issue_ok) begin
      st_d[bus.issue_core]   = conflict ? STALL : RUN;
      lp_d[bus.issue_core]   = bus.issue_lp;
      time_d[bus.issue_core] = bus.issue_time;
    end

    stall_d      = '0;
    active_cnt_d = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      stall_d[c] = (st_d[c] == STALL);
      if (st_d[c] != IDLE) active_cnt_d = active_cnt_d + (NB_COREID+1)'(1);
    end

    release_vld_d  = rel_found;
    release_core_d = rel_found ? rel_core : release_core_q;
    err_d          = (bus.issue_vld && !issue_ok) || (bus.retire_vld && !retire_ok);

    // Sweep uses the table as it stood at the start of the cycle; padded slots never match.
    acc_n = acc_q;
    for (int c = 0; c < NUM_CORE; c++) begin
      if ((c / SCAN_WIDTH) == int'(grp_q) && st_q[c] != IDLE && time_q[c] < acc_n)
        acc_n = time_q[c];
    end
    msg_n = msg_q;
    if (bus.issue_vld && bus.issue_time < msg_n) msg_n = bus.issue_time;

    if (int'(grp_q) == NUM_GRP - 1) begin
      gvt_d     = (acc_n < msg_n) ? acc_n : msg_n;
      gvt_vld_d = 1'b1;
      acc_d     = '1;
      msg_d     = '1;
      grp_d     = '0;
    end else begin
      gvt_d     = gvt_q;
      gvt_vld_d = 1'b0;
      acc_d     = acc_n;
      msg_d     = msg_n;
      grp_d     = grp_q + NB_GRP'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CORE; c++) begin
        st_q[c]   <= IDLE;
        lp_q[c]   <= '0;
        time_q[c] <= '0;
      end
      stall_q        <= '0;
      release_vld_q  <= 1'b0;
      release_core_q <= '0;
      active_cnt_q   <= '0;
      gvt_q          <= '1;
      gvt_vld_q      <= 1'b0;
      err_q          <= 1'b0;
      grp_q          <= '0;
      acc_q          <= '1;
      msg_q          <= '1;
    end else begin
      for (int c = 0; c < NUM_CORE; c++) begin
        st_q[c]   <= st_d[c];
        lp_q[c]   <= lp_d[c];
        time_q[c] <= time_d[c];
      end
      stall_q        <= stall_d;
      release_vld_q  <= release_vld_d;
      release_core_q <= release_core_d;
      active_cnt_q   <= active_cnt_d;
      gvt_q          <= gvt_d;
      gvt_vld_q      <= gvt_vld_d;
      err_q          <= err_d;
      grp_q          <= grp_d;
      acc_q          <= acc_d;
      msg_q          <= msg_d;
    end
  end

  assign bus.stall        = stall_q;
  assign bus.release_vld  = release_vld_q;
  assign bus.release_core = release_core_q;
  assign bus.active_cnt   = active_cnt_q;
  assign bus.gvt          = gvt_q;
  assign bus.gvt_vld      = gvt_vld_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_lp_core_arbiter.sv
// Directed bench for lp_core_arbiter with 5 cores and a 2-wide GVT sweep.
module tb_lp_core_arbiter;
  localparam int NUM_CORE   = 5;
  localparam int NUM_LP     = 64;
  localparam int TIME_WID   = 16;
  localparam int SCAN_WIDTH = 2;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  lp_core_arbiter_if #(.NUM_CORE(NUM_CORE), .NUM_LP(NUM_LP), .TIME_WID(TIME_WID)) bus ();

  lp_core_arbiter #(
    .NUM_CORE(NUM_CORE), .NUM_LP(NUM_LP), .TIME_WID(TIME_WID), .SCAN_WIDTH(SCAN_WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.issue_vld   = 1'b0;
    bus.issue_core  = '0;
    bus.issue_lp    = '0;
    bus.issue_time  = '0;
    bus.retire_vld  = 1'b0;
    bus.retire_core = '0;
  endtask

  // One clock with the given request; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic iv, input int ic, input int il, input int it,
                     input logic rv, input int rc);
    bus.issue_vld   = iv;
    bus.issue_core  = 3'(ic);
    bus.issue_lp    = 6'(il);
    bus.issue_time  = 16'(it);
    bus.retire_vld  = rv;
    bus.retire_core = 3'(rc);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic issue(input int ic, input int il, input int it);
    cyc(1'b1, ic, il, it, 1'b0, 0);
  endtask

  task automatic retire(input int rc);
    cyc(1'b0, 0, 0, 0, 1'b1, rc);
  endtask

  task automatic nop();
    cyc(1'b0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle_inputs();
    reset = 1'b1;
    #12;
    chk("rst_stall",   32'(bus.stall), 0);
    chk("rst_rel_vld", 32'(bus.release_vld), 0);
    chk("rst_rel_core",32'(bus.release_core), 0);
    chk("rst_active",  32'(bus.active_cnt), 0);
    chk("rst_gvt",     32'(bus.gvt), 32'hFFFF);
    chk("rst_gvt_vld", 32'(bus.gvt_vld), 0);
    chk("rst_err",     32'(bus.err), 0);
    do_reset();

    // GVT sweep: 3 groups, busy times {40,12,-,33,-}
    issue(0, 10, 40);
    chk("gvt1_vld_c1", 32'(bus.gvt_vld), 0);
    issue(1, 11, 12);
    chk("gvt1_vld_c2", 32'(bus.gvt_vld), 0);
    issue(3, 12, 33);
    chk("gvt1_vld", 32'(bus.gvt_vld), 1);
    chk("gvt1_val", 32'(bus.gvt), 12);
    nop();
    chk("gvt2_vld_c4", 32'(bus.gvt_vld), 0);
    chk("gvt2_hold",   32'(bus.gvt), 12);
    issue(2, 13, 7);
    chk("gvt2_vld_c5", 32'(bus.gvt_vld), 0);
    nop();
    chk("gvt2_vld", 32'(bus.gvt_vld), 1);
    chk("gvt2_val", 32'(bus.gvt), 7);
    retire(2);
    nop();
    nop();
    chk("gvt3_vld", 32'(bus.gvt_vld), 1);
    chk("gvt3_val", 32'(bus.gvt), 12);
    retire(0);
    retire(1);
    retire(3);
    chk("gvt4_val", 32'(bus.gvt), 12);
    chk("gvt4_active", 32'(bus.active_cnt), 0);
    nop();
    nop();
    nop();
    chk("gvt5_vld", 32'(bus.gvt_vld), 1);
    chk("gvt5_empty", 32'(bus.gvt), 32'hFFFF);

    // Basic serialisation on LP5
    do_reset();
    issue(0, 5, 10);
    chk("a_stall0", 32'(bus.stall), 0);
    chk("a_active1", 32'(bus.active_cnt), 1);
    issue(1, 5, 20);
    chk("a_stall1", 32'(bus.stall), 32'b00010);
    chk("a_active2", 32'(bus.active_cnt), 2);
    retire(0);
    chk("a_rel_stall", 32'(bus.stall), 0);
    chk("a_rel_vld", 32'(bus.release_vld), 1);
    chk("a_rel_core", 32'(bus.release_core), 1);
    chk("a_active3", 32'(bus.active_cnt), 1);
    nop();
    chk("a_rel_pulse", 32'(bus.release_vld), 0);
    retire(1);
    chk("a_active0", 32'(bus.active_cnt), 0);

    // Min-timestamp release order on LP3
    issue(0, 3, 50);
    issue(1, 3, 40);
    issue(2, 3, 30);
    chk("b_stall", 32'(bus.stall), 32'b00110);
    retire(0);
    chk("b_rel1", 32'(bus.release_core), 2);
    chk("b_stall1", 32'(bus.stall), 32'b00010);
    retire(2);
    chk("b_rel2", 32'(bus.release_core), 1);
    chk("b_rel2_vld", 32'(bus.release_vld), 1);
    chk("b_stall2", 32'(bus.stall), 0);
    retire(1);
    chk("b_norel", 32'(bus.release_vld), 0);

    // Tie on timestamp goes to lowest index
    issue(0, 7, 1);
    issue(1, 7, 9);
    issue(3, 7, 9);
    chk("c_stall", 32'(bus.stall), 32'b01010);
    retire(0);
    chk("c_tie", 32'(bus.release_core), 1);
    chk("c_stall1", 32'(bus.stall), 32'b01000);
    retire(1);
    chk("c_rel3", 32'(bus.release_core), 3);
    retire(3);
    chk("c_active", 32'(bus.active_cnt), 0);

    // Same-cycle retire + issue
    issue(0, 2, 5);
    cyc(1'b1, 0, 2, 5, 1'b1, 0);
    chk("d_stall", 32'(bus.stall), 0);
    chk("d_err", 32'(bus.err), 0);
    chk("d_active", 32'(bus.active_cnt), 1);
    chk("d_norel", 32'(bus.release_vld), 0);
    issue(1, 2, 6);
    chk("d_wait", 32'(bus.stall), 32'b00010);
    cyc(1'b1, 0, 2, 1, 1'b1, 0);
    chk("d_reuse_stall", 32'(bus.stall), 32'b00001);
    chk("d_reuse_rel", 32'(bus.release_core), 1);
    chk("d_reuse_active", 32'(bus.active_cnt), 2);
    chk("d_reuse_err", 32'(bus.err), 0);
    retire(1);
    chk("d_rel0", 32'(bus.release_core), 0);
    chk("d_rel0_stall", 32'(bus.stall), 0);
    retire(0);

    // Illegal requests
    issue(0, 4, 8);
    chk("e_no_err", 32'(bus.err), 0);
    issue(0, 9, 3);
    chk("e_err_busy", 32'(bus.err), 1);
    chk("e_active_busy", 32'(bus.active_cnt), 1);
    issue(1, 4, 2);
    chk("e_lp_kept", 32'(bus.stall), 32'b00010);
    chk("e_err_clear", 32'(bus.err), 0);
    retire(2);
    chk("e_err_idle", 32'(bus.err), 1);
    chk("e_active_idle", 32'(bus.active_cnt), 2);
    retire(6);
    chk("e_err_rid", 32'(bus.err), 1);
    issue(7, 0, 0);
    chk("e_err_iid", 32'(bus.err), 1);
    chk("e_active_iid", 32'(bus.active_cnt), 2);
    retire(1);
    chk("e_err_stall", 32'(bus.err), 1);
    chk("e_stall_kept", 32'(bus.stall), 32'b00010);
    cyc(1'b1, 2, 20, 1, 1'b1, 3);
    chk("e_pair_err", 32'(bus.err), 1);
    chk("e_pair_active", 32'(bus.active_cnt), 3);
    nop();
    chk("e_err_pulse", 32'(bus.err), 0);

    // Asynchronous reset drops a pending release
    do_reset();
    issue(0, 1, 3);
    issue(1, 1, 4);
    retire(0);
    chk("f_rel_pre", 32'(bus.release_vld), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("f_rel_drop", 32'(bus.release_vld), 0);
    chk("f_stall", 32'(bus.stall), 0);
    chk("f_active", 32'(bus.active_cnt), 0);
    chk("f_gvt", 32'(bus.gvt), 32'hFFFF);
    chk("f_gvt_vld", 32'(bus.gvt_vld), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    nop();
    chk("f_after", 32'(bus.active_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
